// File: rtl/ram_ctrl_pkg.sv
// Shared types, constants and helpers for the RAM-backed FIFO controller.
package ram_ctrl_pkg;

    localparam int DATA_WIDTH_DFLT = 8;
    localparam int ADDR_WIDTH_DFLT = 6;

    // Cycles from ram_raddr to valid ram_q.
    localparam int RAM_RD_LATENCY  = 1;

    // Output buffer must cover the read latency plus the word being presented.
    localparam int OBUF_DEPTH      = RAM_RD_LATENCY + 1;

    // Occupancy of the 2-entry output buffer (0..2).
    typedef logic [1:0] obuf_cnt_t;

    // Number of RAM words addressable with the given address width.
    function automatic int ram_depth(input int addr_width);
        return 32'd1 << addr_width;
    endfunction

endpackage

// File: rtl/ram_fifo_ctrl_if.sv
// Stream and RAM port bundle of the RAM FIFO controller.
interface ram_fifo_ctrl_if #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 6
);
    logic                  s_valid;
    logic                  s_ready;
    logic [DATA_WIDTH-1:0] s_data;
    logic                  m_valid;
    logic                  m_ready;
    logic [DATA_WIDTH-1:0] m_data;
    logic                  ram_we;
    logic [ADDR_WIDTH-1:0] ram_waddr;
    logic [DATA_WIDTH-1:0] ram_wdata;
    logic [ADDR_WIDTH-1:0] ram_raddr;
    logic [DATA_WIDTH-1:0] ram_q;
    logic [ADDR_WIDTH+1:0] level;

    // Controller side: drives handshake responses, RAM controls and level.
    modport master (
        input  s_valid, s_data, m_ready, ram_q,
        output s_ready, m_valid, m_data, ram_we, ram_waddr, ram_wdata, ram_raddr, level
    );

    // Environment side: producer, consumer and RAM.
    modport slave (
        output s_valid, s_data, m_ready, ram_q,
        input  s_ready, m_valid, m_data, ram_we, ram_waddr, ram_wdata, ram_raddr, level
    );
endinterface

// File: rtl/ram_fifo_obuf.sv
// Two-entry first-word-fall-through output buffer fed by RAM read returns.
module ram_fifo_obuf
    import ram_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DFLT
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_push,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_pop,
    output logic [DATA_WIDTH-1:0] o_data,
    output obuf_cnt_t             o_cnt
);

    logic [DATA_WIDTH-1:0] r_head;
    logic [DATA_WIDTH-1:0] r_tail;
    obuf_cnt_t             r_cnt;

    // Head/tail storage and count; a pop shifts tail to head, a return fills the first free slot.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_head <= {DATA_WIDTH{1'b0}};
            r_tail <= {DATA_WIDTH{1'b0}};
            r_cnt  <= 2'd0;
        end else begin
            case ({i_push, i_pop})
                2'b10: begin
                    if (r_cnt == 2'd0) begin
                        r_head <= i_data;
                    end else begin
                        r_tail <= i_data;
                    end
                    r_cnt <= r_cnt + 2'd1;
                end
                2'b01: begin
                    r_head <= r_tail;
                    r_cnt  <= r_cnt - 2'd1;
                end
                2'b11: begin
                    // Count unchanged: the returning word takes the slot the pop frees.
                    if (r_cnt == 2'd1) begin
                        r_head <= i_data;
                    end else begin
                        r_head <= r_tail;
                        r_tail <= i_data;
                    end
                end
                default: begin
                    r_cnt <= r_cnt;
                end
            endcase
        end
    end

    assign o_data = r_head;
    assign o_cnt  = r_cnt;

endmodule

// File: rtl/ram_fifo_ctrl.sv
// Sequences an external 1-cycle-read dual-port RAM as a full-throughput FIFO.
module ram_fifo_ctrl
    import ram_ctrl_pkg::*;
#(
    parameter int DATA_WIDTH = DATA_WIDTH_DFLT,
    parameter int ADDR_WIDTH = ADDR_WIDTH_DFLT
) (
    input logic            clk,
    input logic            rst_n,
    ram_fifo_ctrl_if.master bus
);

    localparam int RAM_DEPTH = ram_depth(ADDR_WIDTH);

    typedef logic [ADDR_WIDTH-1:0] ptr_t;
    typedef logic [ADDR_WIDTH:0]   cnt_t;
    typedef logic [ADDR_WIDTH+1:0] lvl_t;

    localparam cnt_t FULL_CNT = cnt_t'(RAM_DEPTH);

    ptr_t      r_wptr;
    ptr_t      r_rptr;
    cnt_t      r_ram_cnt;
    logic      r_rd_inflight;

    logic      w_s_ready;
    logic      w_push;
    logic      w_m_valid;
    logic      w_pop;
    logic      w_rd_issue;
    logic [2:0] w_occ;
    obuf_cnt_t w_buf_cnt;

    // Push acceptance depends only on registered RAM occupancy.
    assign w_s_ready = (r_ram_cnt != FULL_CNT);
    assign w_push    = bus.s_valid & w_s_ready;
    assign w_m_valid = (w_buf_cnt != 2'd0);
    assign w_pop     = w_m_valid & bus.m_ready;

    // Words that will sit in the buffer after this edge, excluding a new read.
    assign w_occ      = {1'b0, w_buf_cnt} + {2'b00, r_rd_inflight} - {2'b00, w_pop};
    // ram_cnt excludes this cycle's write, so the read never hits the address being written.
    assign w_rd_issue = (r_ram_cnt != {(ADDR_WIDTH+1){1'b0}}) & (w_occ < 3'(OBUF_DEPTH));

    // Pointer, RAM occupancy and read-in-flight tracking.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wptr        <= {ADDR_WIDTH{1'b0}};
            r_rptr        <= {ADDR_WIDTH{1'b0}};
            r_ram_cnt     <= {(ADDR_WIDTH+1){1'b0}};
            r_rd_inflight <= 1'b0;
        end else begin
            r_wptr        <= r_wptr + ptr_t'(w_push);
            r_rptr        <= r_rptr + ptr_t'(w_rd_issue);
            r_ram_cnt     <= r_ram_cnt + cnt_t'(w_push) - cnt_t'(w_rd_issue);
            r_rd_inflight <= w_rd_issue;
        end
    end

    ram_fifo_obuf #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_obuf (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_push (r_rd_inflight),
        .i_data (bus.ram_q),
        .i_pop  (w_pop),
        .o_data (bus.m_data),
        .o_cnt  (w_buf_cnt)
    );

    assign bus.s_ready   = w_s_ready;
    assign bus.m_valid   = w_m_valid;
    assign bus.ram_we    = w_push;
    assign bus.ram_waddr = r_wptr;
    assign bus.ram_wdata = bus.s_data;
    assign bus.ram_raddr = r_rptr;
    assign bus.level     = lvl_t'(r_ram_cnt) + lvl_t'(r_rd_inflight) + lvl_t'(w_buf_cnt);

endmodule

// File: tb/tb_ram_fifo_ctrl.sv
// Bench for ram_fifo_ctrl with a behavioural RAM and a queue-based FIFO model.
module tb_ram_fifo_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    ram_fifo_ctrl_if #(.DATA_WIDTH(8), .ADDR_WIDTH(3)) bus_if ();

    ram_fifo_ctrl #(.DATA_WIDTH(8), .ADDR_WIDTH(3)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus_if)
    );

    // Dual-port RAM model: registered read, read-before-write.
    logic [7:0] mem [8];
    logic [7:0] q_r = 8'h00;
    always @(posedge clk) begin
        q_r <= mem[bus_if.ram_raddr];
        if (bus_if.ram_we) mem[bus_if.ram_waddr] <= bus_if.ram_wdata;
    end
    assign bus_if.ram_q = q_r;

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    // Model: words held, with the edge at which each was accepted.
    logic [7:0] mq [$];
    int         mt [$];
    logic [7:0] got_q [$];
    bit         prev_stall = 1'b0;
    logic [7:0] prev_data = 8'h00;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    // Per-cycle check at the falling edge, then advance the model for the coming rising edge.
    task automatic compare();
        logic exp_v;
        cyc++;
        exp_v = (mq.size() > 0) && (mt[0] <= cyc - 2);
        chk("level", 32'(bus_if.level), 32'(mq.size()));
        chk("m_valid", 32'(bus_if.m_valid), 32'(exp_v));
        if (exp_v) chk("m_data", 32'(bus_if.m_data), 32'(mq[0]));
        if (prev_stall) begin
            chk("stall_valid", 32'(bus_if.m_valid), 32'd1);
            chk("stall_data", 32'(bus_if.m_data), 32'(prev_data));
        end
        if (mq.size() < 8)   chk("s_ready_room", 32'(bus_if.s_ready), 32'd1);
        if (mq.size() == 10) chk("s_ready_full", 32'(bus_if.s_ready), 32'd0);
        chk("ram_we", 32'(bus_if.ram_we), 32'(bus_if.s_valid & bus_if.s_ready));
        if (bus_if.ram_we) chk("ram_wdata", 32'(bus_if.ram_wdata), 32'(bus_if.s_data));
        if (!rst_n) begin
            mq.delete();
            mt.delete();
            prev_stall = 1'b0;
        end else begin
            if (exp_v && bus_if.m_ready) begin
                got_q.push_back(bus_if.m_data);
                void'(mq.pop_front());
                void'(mt.pop_front());
            end
            if (bus_if.s_valid && bus_if.s_ready) begin
                mq.push_back(bus_if.s_data);
                mt.push_back(cyc + 1);
            end
            prev_stall = exp_v && !bus_if.m_ready;
            prev_data  = bus_if.m_data;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_got(input int n, input int budget, input string name);
        int k;
        k = 0;
        while (got_q.size() < n && k < budget) begin
            tick();
            k++;
        end
        chk(name, 32'(got_q.size() >= n), 32'd1);
    endtask

    initial begin
        int acc;
        int base;
        int pushed;
        int k;
        logic [7:0] d;
        bus_if.s_valid = 1'b0;
        bus_if.s_data  = 8'h00;
        bus_if.m_ready = 1'b0;
        fork
            begin
                forever begin
                    @(negedge clk);
                    compare();
                end
            end
            begin
                // Reset held for two edges.
                repeat (2) @(posedge clk);
                #1 rst_n = 1'b1;
                #1;
                chk("rst_m_valid", 32'(bus_if.m_valid), 32'd0);
                chk("rst_s_ready", 32'(bus_if.s_ready), 32'd1);
                chk("rst_level",   32'(bus_if.level),   32'd0);
                chk("rst_ram_we",  32'(bus_if.ram_we),  32'd0);

                // Single word, two-edge latency.
                tick();
                bus_if.s_valid = 1'b1; bus_if.s_data = 8'hA5; bus_if.m_ready = 1'b1;
                tick();
                bus_if.s_valid = 1'b0;
                chk("lat_edge0_valid", 32'(bus_if.m_valid), 32'd0);
                tick();
                chk("lat_edge1_valid", 32'(bus_if.m_valid), 32'd0);
                tick();
                chk("lat_edge2_valid", 32'(bus_if.m_valid), 32'd1);
                chk("lat_edge2_data",  32'(bus_if.m_data),  32'hA5);
                chk("lat_edge2_level", 32'(bus_if.level),   32'd1);
                tick();
                chk("after_pop_level", 32'(bus_if.level),   32'd0);

                // Fill with consumer stalled: 8 RAM words plus 2 buffered.
                bus_if.m_ready = 1'b0;
                acc = 0;
                for (int i = 0; i < 12; i++) begin
                    tick();
                    bus_if.s_valid = 1'b1;
                    bus_if.s_data  = 8'(i);
                    if (bus_if.s_ready) acc++;
                end
                tick();
                bus_if.s_valid = 1'b0;
                chk("fill_accepted", 32'(acc), 32'd10);
                chk("fill_level",    32'(bus_if.level),   32'd10);
                chk("fill_s_ready",  32'(bus_if.s_ready), 32'd0);
                base = got_q.size();
                bus_if.m_ready = 1'b1;
                wait_got(base + 10, 40, "fill_drain_done");
                for (int i = 0; i < 10; i++) begin
                    if (base + i < got_q.size()) chk("fill_order", 32'(got_q[base + i]), 32'(i));
                end

                // Streaming across pointer wrap.
                base = got_q.size();
                pushed = 0;
                for (int i = 0; i < 40; i++) begin
                    tick();
                    bus_if.s_valid = 1'b1;
                    bus_if.s_data  = 8'(8'h40 + pushed);
                    if (bus_if.s_ready) pushed++;
                end
                tick();
                bus_if.s_valid = 1'b0;
                chk("stream_accepted", 32'(pushed), 32'd40);
                wait_got(base + 40, 20, "stream_drain_done");
                if (got_q.size() >= base + 40) begin
                    d = got_q[base + 39];
                    chk("stream_last", 32'(d), 32'h67);
                end

                // Random backpressure, 100 words.
                pushed = 0;
                k = 0;
                base = got_q.size();
                while (pushed < 100 && k < 1000) begin
                    tick();
                    k++;
                    bus_if.m_ready = 1'($urandom_range(0, 1));
                    bus_if.s_valid = 1'b1;
                    bus_if.s_data  = 8'(8'h80 + pushed);
                    if (bus_if.s_ready) pushed++;
                end
                tick();
                bus_if.s_valid = 1'b0;
                chk("bp_pushed", 32'(pushed), 32'd100);
                bus_if.m_ready = 1'b1;
                wait_got(base + 100, 200, "bp_drain_done");

                // Reset with five words held.
                bus_if.m_ready = 1'b0;
                for (int i = 0; i < 5; i++) begin
                    tick();
                    bus_if.s_valid = 1'b1;
                    bus_if.s_data  = 8'(8'h50 + i);
                end
                tick();
                bus_if.s_valid = 1'b0;
                chk("pre_rst_level", 32'(bus_if.level), 32'd5);
                rst_n = 1'b0;
                tick();
                rst_n = 1'b1;
                chk("mid_rst_level",   32'(bus_if.level),   32'd0);
                chk("mid_rst_m_valid", 32'(bus_if.m_valid), 32'd0);
                base = got_q.size();
                bus_if.s_valid = 1'b1; bus_if.s_data = 8'h3C; bus_if.m_ready = 1'b1;
                tick();
                bus_if.s_valid = 1'b0;
                wait_got(base + 1, 10, "post_rst_out");
                if (got_q.size() > base) chk("post_rst_first", 32'(got_q[base]), 32'h3C);
                repeat (3) tick();
            end
        join_any
        disable fork;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
